lcd_write_arbiter: RTL and testbench

- Shares the single character-write port of the 2x16 LCD driver (index/char/go/done) among NUM_REQ independent requesters.
- Round-robin grant. Checks each target address against the visible 2x16 map. Holds go until the driver accepts, including through its power-up init period, then returns a one-cycle ack to the winner.
- Sits between application-level writers (status display, counters, debug) and the LCD driver instance.

---
 rtl/lcd_arb_pkg.sv | 32 +++
 rtl/lcd_write_arbiter_rr_pick.sv | 30 +++
 rtl/lcd_write_arbiter.sv | 170 +++++++++++++++++
 tb/tb_lcd_write_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_arb_pkg.sv
// Shared types, LCD address map and state encoding for the LCD write arbiter.
package lcd_arb_pkg;

  localparam int unsigned IDX_W = 7;
  localparam int unsigned CHR_W = 8;
  localparam int unsigned TMO_W = 20;

  localparam logic [IDX_W-1:0] LINE1_BASE = 7'h00;
  localparam logic [IDX_W-1:0] LINE2_BASE = 7'h40;
  localparam int unsigned      LINE_LEN   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ACK   = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic [CHR_W-1:0] chr;
  } lcd_wr_t;

  // Offsets wrap modulo 2^7, so an address below a line base becomes large and fails the compare.
  function automatic logic index_valid(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] off1;
    logic [IDX_W-1:0] off2;
    off1 = idx - LINE1_BASE;
    off2 = idx - LINE2_BASE;
    return (off1 < IDX_W'(LINE_LEN)) || (off2 < IDX_W'(LINE_LEN));
  endfunction

endpackage

// File: rtl/lcd_write_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping.
module lcd_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_c,
  output logic [PTR_W-1:0]   win_idx_c,
  output logic               any_c
);

  always_comb begin : p_pick
    int unsigned slot;
    slot      = 0;
    win_c     = '0;
    win_idx_c = '0;
    any_c     = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      slot = 32'(ptr) + k;
      if (slot >= NUM_REQ) slot = slot - NUM_REQ;
      if (!any_c && req[PTR_W'(slot)]) begin
        win_c[PTR_W'(slot)] = 1'b1;
        win_idx_c           = PTR_W'(slot);
        any_c               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Round-robin arbiter sharing the LCD driver's single character-write port among NUM_REQ requesters.
// Optional ISSUE watchdog enabled by defining LCD_ARB_TIMEOUT_EN.
module lcd_write_arbiter
  import lcd_arb_pkg::*;
#(
  parameter int unsigned       NUM_REQ     = 4,
  parameter logic [TMO_W-1:0]  TIMEOUT_CYC = 20'hFFFFF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*IDX_W-1:0] req_index,
  input  logic [NUM_REQ*CHR_W-1:0] req_char,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     err,
  output logic                     busy,
  output logic                     lcd_go,
  output logic [IDX_W-1:0]         lcd_index,
  output logic [CHR_W-1:0]         lcd_char,
  input  logic                     lcd_done
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  arb_state_e          state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                err_q, err_d;
  logic                err_flag_q, err_flag_d;
  logic                busy_q, busy_d;
  logic                go_q, go_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic [CHR_W-1:0]    chr_q, chr_d;

  logic [NUM_REQ-1:0]  win_c;
  logic [PTR_W-1:0]    win_idx_c;
  logic                any_c;
  logic                tmo_c;
  lcd_wr_t             slot_wr [NUM_REQ];
  lcd_wr_t             win_wr_c;

  // Unpack the flat request buses into per-requester payloads.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign slot_wr[i] = '{index: req_index[IDX_W*i +: IDX_W], chr: req_char[CHR_W*i +: CHR_W]};
  end

  assign win_wr_c = slot_wr[win_idx_c];

  lcd_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req       (req),
    .ptr       (ptr_q),
    .win_c     (win_c),
    .win_idx_c (win_idx_c),
    .any_c     (any_c)
  );

`ifdef LCD_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] cnt_q, cnt_d;

  // Counter is zero outside ISSUE, so it starts cleared on every ISSUE entry.
  always_comb begin
    cnt_d = '0;
    if (state_q == ST_ISSUE) cnt_d = cnt_q + TMO_W'(1);
  end

  assign tmo_c = (state_q == ST_ISSUE) && (cnt_d == TIMEOUT_CYC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign tmo_c          = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    gnt_d      = gnt_q;
    err_flag_d = err_flag_q;
    index_d    = index_q;
    chr_d      = chr_q;

    unique case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (any_c) begin
          gnt_d   = win_c;
          owner_d = win_idx_c;
          index_d = win_wr_c.index;
          chr_d   = win_wr_c.chr;
          if (index_valid(win_wr_c.index)) begin
            err_flag_d = 1'b0;
            state_d    = ST_ISSUE;
          end else begin
            err_flag_d = 1'b1;
            state_d    = ST_ACK;
          end
        end
      end
      ST_ISSUE: begin
        if (lcd_done) begin
          err_flag_d = 1'b0;
          state_d    = ST_ACK;
        end else if (tmo_c) begin
          err_flag_d = 1'b1;
          state_d    = ST_ACK;
        end
      end
      ST_ACK: begin
        ptr_d   = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    ack_d  = (state_d == ST_ACK) ? gnt_d : '0;
    err_d  = (state_d == ST_ACK) && err_flag_d;
    busy_d = (state_d != ST_IDLE);
    go_d   = (state_d == ST_ISSUE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      gnt_q      <= '0;
      ack_q      <= '0;
      err_q      <= 1'b0;
      err_flag_q <= 1'b0;
      busy_q     <= 1'b0;
      go_q       <= 1'b0;
      index_q    <= '0;
      chr_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      err_flag_q <= err_flag_d;
      busy_q     <= busy_d;
      go_q       <= go_d;
      index_q    <= index_d;
      chr_q      <= chr_d;
    end
  end

  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign lcd_go    = go_q;
  assign lcd_index = index_q;
  assign lcd_char  = chr_q;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Scoreboard bench for lcd_write_arbiter with a behavioural LCD driver (init period + fixed write latency).
module tb_lcd_write_arbiter;

  localparam int N        = 4;
  localparam int INIT_CYC = 30;
  localparam int DRV_LAT  = 3;
  localparam int WR_GO    = DRV_LAT + 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*7-1:0] req_index;
  logic [N*8-1:0] req_char;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic           err;
  logic           busy;
  logic           lcd_go;
  logic [6:0]     lcd_index;
  logic [7:0]     lcd_char;
  logic           lcd_done;

  lcd_write_arbiter #(
    .NUM_REQ     (N),
    .TIMEOUT_CYC (20'd100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_index (req_index),
    .req_char  (req_char),
    .gnt       (gnt),
    .ack       (ack),
    .err       (err),
    .busy      (busy),
    .lcd_go    (lcd_go),
    .lcd_index (lcd_index),
    .lcd_char  (lcd_char),
    .lcd_done  (lcd_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         slot;
    logic       e;
    logic [6:0] idx;
    logic [7:0] chr;
    int         min_go;
    int         max_go;
    int         lat;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         raise_cyc[N];
  int         go_cnt = 0;
  logic [N-1:0] clr_mask = '0;
  int         drv_writes = 0;
  bit         drv_hang = 1'b0;
  bit         stray = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  task automatic expect_wr(input int s, input logic e, input logic [6:0] idx, input logic [7:0] ch,
                           input int lo, input int hi, input int lat);
    exp_t x;
    x.slot = s; x.e = e; x.idx = idx; x.chr = ch;
    x.min_go = lo; x.max_go = hi; x.lat = lat;
    exp_q.push_back(x);
  endtask

  // Caller is already at a posedge + 2 time units.
  task automatic post(input int s, input logic [6:0] idx, input logic [7:0] ch);
    req_index[7*s +: 7] = idx;
    req_char[8*s +: 8]  = ch;
    req[s]              = 1'b1;
    raise_cyc[s]        = cyc;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (!(exp_q.size() == 0 && busy === 1'b0 && req == '0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!(exp_q.size() == 0 && busy === 1'b0 && req == '0)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle: still busy=%b pending=%0d after %0d cycles, required idle", busy, exp_q.size(), budget);
    end
  endtask

  // Monitor: pops the scoreboard on every ack pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        go_cnt = 0;
      end else begin
        if (lcd_go) go_cnt++;
        if (ack != '0) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_ack: got ack=%b err=%b, required no ack", ack, err);
          end else begin
            e = exp_q.pop_front();
            chk("ack_vec",   32'(ack), 32'(1 << e.slot));
            chk("ack_gnt",   32'(gnt), 32'(1 << e.slot));
            chk("ack_err",   32'(err), 32'(e.e));
            chk("ack_index", 32'(lcd_index), 32'(e.idx));
            chk("ack_char",  32'(lcd_char), 32'(e.chr));
            chk("ack_go_low", 32'(lcd_go), 32'd0);
            chk_range("go_cycles", go_cnt, e.min_go, e.max_go);
            if (e.lat >= 0) chk("ack_latency", 32'(cyc - raise_cyc[e.slot]), 32'(e.lat));
          end
          go_cnt   = 0;
          clr_mask = ack;
        end
      end
    end
  end

  // Requesters drop req on the edge that ends their ack cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (clr_mask != '0) begin
        req      = req & ~clr_mask;
        clr_mask = '0;
      end
    end
  end

  // LCD driver model: ignores go during init, then answers each go with done after DRV_LAT cycles.
  initial begin
    int init_left;
    int lat_left;
    bit dbusy;
    lcd_done  = 1'b0;
    init_left = INIT_CYC;
    lat_left  = 0;
    dbusy     = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      lcd_done = 1'b0;
      if (!rst_n) begin
        init_left = INIT_CYC;
        dbusy     = 1'b0;
      end else if (stray) begin
        lcd_done = 1'b1;
        stray    = 1'b0;
      end else if (init_left > 0) begin
        init_left--;
      end else if (dbusy) begin
        if (!drv_hang) begin
          lat_left--;
          if (lat_left == 0) begin
            lcd_done = 1'b1;
            dbusy    = 1'b0;
            drv_writes++;
          end
        end
      end else if (lcd_go) begin
        dbusy    = 1'b1;
        lat_left = DRV_LAT;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n     = 1'b0;
    req       = '0;
    req_index = '0;
    req_char  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt",   32'(gnt), 32'd0);
    chk("rst_ack",   32'(ack), 32'd0);
    chk("rst_err",   32'(err), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_go",    32'(lcd_go), 32'd0);
    chk("rst_index", 32'(lcd_index), 32'd0);
    chk("rst_char",  32'(lcd_char), 32'd0);

    // Request raised with reset release: go must be held through driver init.
    @(posedge clk); #2;
    rst_n = 1'b1;
    expect_wr(2, 1'b0, 7'h40, 8'h5A, INIT_CYC + 1, INIT_CYC + WR_GO, -1);
    post(2, 7'h40, 8'h5A);
    wait_idle(200);

    // Single write after init.
    @(posedge clk); #2;
    expect_wr(0, 1'b0, 7'h05, 8'h41, WR_GO, WR_GO, -1);
    post(0, 7'h05, 8'h41);
    wait_idle(50);

    // Address-map boundaries: rejected ones ack one cycle after sampling with no go.
    @(posedge clk); #2;
    expect_wr(1, 1'b1, 7'h10, 8'h23, 0, 0, 1);
    post(1, 7'h10, 8'h23);
    wait_idle(50);
    @(posedge clk); #2;
    expect_wr(1, 1'b1, 7'h3F, 8'h24, 0, 0, 1);
    post(1, 7'h3F, 8'h24);
    wait_idle(50);
    @(posedge clk); #2;
    expect_wr(2, 1'b0, 7'h4F, 8'h25, WR_GO, WR_GO, -1);
    post(2, 7'h4F, 8'h25);
    wait_idle(50);
    @(posedge clk); #2;
    expect_wr(3, 1'b1, 7'h50, 8'h26, 0, 0, 1);
    post(3, 7'h50, 8'h26);
    wait_idle(50);
    @(posedge clk); #2;
    expect_wr(0, 1'b0, 7'h0F, 8'h27, WR_GO, WR_GO, -1);
    post(0, 7'h0F, 8'h27);
    wait_idle(50);

    // Stray done while idle must not start anything.
    @(posedge clk); #2;
    stray = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stray_busy", 32'(busy), 32'd0);
    end

    // Reset while go is high: outputs clear asynchronously.
    @(posedge clk); #2;
    post(3, 7'h07, 8'h33);
    k = 0;
    while (lcd_go !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("midrst_go_seen", 32'(lcd_go), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_gnt",   32'(gnt), 32'd0);
    chk("midrst_ack",   32'(ack), 32'd0);
    chk("midrst_err",   32'(err), 32'd0);
    chk("midrst_busy",  32'(busy), 32'd0);
    chk("midrst_go",    32'(lcd_go), 32'd0);
    chk("midrst_index", 32'(lcd_index), 32'd0);
    chk("midrst_char",  32'(lcd_char), 32'd0);
    exp_q.delete();
    req      = '0;
    clr_mask = '0;
    repeat (2) @(posedge clk);

    // Contention after reset release: pointer is 0, so grants run 0,1,2,3.
    #2;
    rst_n = 1'b1;
    expect_wr(0, 1'b0, 7'h00, 8'h30, INIT_CYC + 1, INIT_CYC + WR_GO, -1);
    expect_wr(1, 1'b0, 7'h01, 8'h31, WR_GO, WR_GO, -1);
    expect_wr(2, 1'b0, 7'h4E, 8'h32, WR_GO, WR_GO, -1);
    expect_wr(3, 1'b0, 7'h0F, 8'h33, WR_GO, WR_GO, -1);
    post(0, 7'h00, 8'h30);
    post(1, 7'h01, 8'h31);
    post(2, 7'h4E, 8'h32);
    post(3, 7'h0F, 8'h33);
    wait_idle(300);

    // Pointer wrapped back to 0 after owner 3.
    @(posedge clk); #2;
    expect_wr(0, 1'b0, 7'h02, 8'h61, WR_GO, WR_GO, -1);
    expect_wr(1, 1'b0, 7'h42, 8'h62, WR_GO, WR_GO, -1);
    post(0, 7'h02, 8'h61);
    post(1, 7'h42, 8'h62);
    wait_idle(100);

    // Pointer is now 2: requester 3 beats requester 0.
    @(posedge clk); #2;
    expect_wr(3, 1'b0, 7'h0A, 8'h71, WR_GO, WR_GO, -1);
    expect_wr(0, 1'b0, 7'h4A, 8'h72, WR_GO, WR_GO, -1);
    post(0, 7'h4A, 8'h72);
    post(3, 7'h0A, 8'h71);
    wait_idle(100);

    chk("driver_writes", 32'(drv_writes), 32'd12);

`ifdef LCD_ARB_TIMEOUT_EN
    // Driver never answers: watchdog ends the write with err after 100 ISSUE cycles.
    @(posedge clk); #2;
    drv_hang = 1'b1;
    expect_wr(0, 1'b1, 7'h01, 8'h21, 100, 100, -1);
    post(0, 7'h01, 8'h21);
    wait_idle(400);
    @(negedge clk);
    chk("tmo_go_after", 32'(lcd_go), 32'd0);
`endif

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
